// File: rtl/tx_frame_fifo.sv
// tx_frame_fifo: single-clock store-and-forward TX frame FIFO; a frame becomes readable only once its last byte is stored.
// Optional in-flight frame abort via wabort is compiled in with `define TX_FIFO_ABORT_EN.
module tx_frame_fifo #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 wvalid,
   output logic                 wready,
   input  logic [7:0]           wdata,
   input  logic                 wlast,
   input  logic                 wabort,
   output logic                 rvalid,
   input  logic                 rready,
   output logic [7:0]           rdata,
   output logic                 rlast,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   frame_cnt,
   output logic                 drop,
   output logic [1:0]           dbg_wr_state
);
   // Handshakes: a byte moves on the write side when wvalid&wready and on the read side when
   // rvalid&rready at a rising clk edge; a valid source holds its byte until it is taken.

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0] L_DEPTH = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0] L_ONE   = (ADDR_BITS+1)'(1);

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_FRAME   = 2'd1,
      WR_DISCARD = 2'd2
   } wr_state_t;

   wr_state_t            r_state;
   wr_state_t            w_state_nxt;
   logic [8:0]           r_mem [DEPTH];
   logic [ADDR_BITS:0]   r_rd_ptr;
   logic [ADDR_BITS:0]   r_wr_cur;
   logic [ADDR_BITS:0]   r_wr_base;
   logic [ADDR_BITS:0]   r_frame_cnt;
   logic                 r_full;
   logic                 r_empty;
   logic                 r_drop;

   logic [ADDR_BITS:0]   w_used;
   logic [ADDR_BITS:0]   w_used_nxt;
   logic [ADDR_BITS:0]   w_rd_ptr_nxt;
   logic [ADDR_BITS:0]   w_wr_cur_nxt;
   logic                 w_wacc;
   logic                 w_racc;
   logic                 w_abort;
   logic                 w_store;
   logic                 w_commit;
   logic                 w_rewind;
   logic                 w_drop_set;

`ifdef TX_FIFO_ABORT_EN
   assign w_abort = wabort && (r_state == WR_FRAME);
`else
   logic w_unused_wabort;
   assign w_unused_wabort = wabort;
   assign w_abort         = 1'b0;
`endif

   assign wready = (r_state == WR_DISCARD) || !r_full;
   assign w_wacc = wvalid && wready;
   assign rvalid = (r_frame_cnt != '0);
   assign w_racc = rvalid && rready;
   assign w_used = r_wr_cur - r_rd_ptr;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= WR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_store     = 1'b0;
      w_commit    = 1'b0;
      w_rewind    = 1'b0;
      w_drop_set  = 1'b0;
      case (r_state)
         WR_IDLE, WR_FRAME: begin
            if (w_abort) begin
               w_rewind    = 1'b1;
               w_drop_set  = 1'b1;
               w_state_nxt = WR_IDLE;
            end else if (w_wacc) begin
               w_store = 1'b1;
               if (wlast) begin
                  w_commit    = 1'b1;
                  w_state_nxt = WR_IDLE;
               end else if ((w_used + L_ONE == L_DEPTH) && (r_frame_cnt == '0)) begin
                  // Frame fills the whole store with no committed data ahead of it: it can never fit.
                  w_rewind    = 1'b1;
                  w_state_nxt = WR_DISCARD;
               end else begin
                  w_state_nxt = WR_FRAME;
               end
            end else if ((r_state == WR_FRAME) && r_full && (r_frame_cnt == '0)) begin
               // Backpressured frame found itself alone in a full store after draining: oversize.
               w_rewind    = 1'b1;
               w_state_nxt = WR_DISCARD;
            end
         end
         WR_DISCARD: begin
            if (w_wacc && wlast) begin
               w_drop_set  = 1'b1;
               w_state_nxt = WR_IDLE;
            end
         end
         default: w_state_nxt = WR_IDLE;
      endcase
   end

   assign w_wr_cur_nxt = w_rewind ? r_wr_base : (w_store ? r_wr_cur + L_ONE : r_wr_cur);
   assign w_rd_ptr_nxt = w_racc ? r_rd_ptr + L_ONE : r_rd_ptr;
   assign w_used_nxt   = w_wr_cur_nxt - w_rd_ptr_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_ptr    <= '0;
         r_wr_cur    <= '0;
         r_wr_base   <= '0;
         r_frame_cnt <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_drop      <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_cur <= w_wr_cur_nxt;
         if (w_commit) begin
            r_wr_base <= r_wr_cur + L_ONE;
         end
         case ({w_commit, w_racc && rlast})
            2'b10:   r_frame_cnt <= r_frame_cnt + L_ONE;
            2'b01:   r_frame_cnt <= r_frame_cnt - L_ONE;
            default: r_frame_cnt <= r_frame_cnt;
         endcase
         r_full  <= (w_used_nxt == L_DEPTH);
         r_empty <= (w_used_nxt == '0);
         r_drop  <= w_drop_set;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wr_cur[ADDR_BITS-1:0]] <= {wlast, wdata};
      end
   end

   assign {rlast, rdata} = r_mem[r_rd_ptr[ADDR_BITS-1:0]];
   assign full           = r_full;
   assign empty          = r_empty;
   assign frame_cnt      = r_frame_cnt;
   assign drop           = r_drop;
   assign dbg_wr_state   = r_state;

endmodule

// File: tb/tb_tx_frame_fifo.sv
// tb_tx_frame_fifo: randomized self-checking bench for tx_frame_fifo (ADDR_BITS=4) against a queue-based frame model.
// The abort scenario is compiled in with `define TX_FIFO_ABORT_EN, matching the DUT build.
`timescale 1ns/1ps
module tb_tx_frame_fifo;
   localparam int AB    = 4;
   localparam int DEPTH = 16;

   logic          clk    = 1'b0;
   logic          rstn   = 1'b0;
   logic          wvalid = 1'b0;
   logic [7:0]    wdata  = 8'h00;
   logic          wlast  = 1'b0;
   logic          wabort = 1'b0;
   logic          rready = 1'b0;
   logic          wready, rvalid, rlast, full, empty, drop;
   logic [7:0]    rdata;
   logic [AB:0]   frame_cnt;
   logic [1:0]    dbg_wr_state;

   always #5 clk = ~clk;

   tx_frame_fifo #(.ADDR_BITS(AB)) dut (
      .clk(clk), .rstn(rstn),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast), .wabort(wabort),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
      .full(full), .empty(empty), .frame_cnt(frame_cnt), .drop(drop),
      .dbg_wr_state(dbg_wr_state)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: committed bytes in read order, the frame being written, and discard/drop flags.
   logic [8:0] exp_q[$];
   logic [8:0] pend_q[$];
   bit         m_disc = 1'b0;
   bit         m_drop = 1'b0;

   logic [8:0] src_q[$];
   logic [8:0] got_q[$];

   // Status word layout: {wready, rvalid, full, empty, drop, frame_cnt[4:0]}.
   logic [9:0] s_stat, e_stat;
   logic [8:0] s_rword, e_rword, h_wword;
   bit         e_rvalid, h_w, h_r;

   function automatic int m_frames();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i][8]) n++;
      return n;
   endfunction

   task automatic tick();
      int used, fr;
      bit e_full, e_wready;
      used      = exp_q.size() + pend_q.size();
      fr        = m_frames();
      e_full    = (used == DEPTH);
      e_wready  = m_disc || !e_full;
      e_rvalid  = (fr != 0);
      e_stat    = {e_wready, e_rvalid, e_full, (used == 0), m_drop, 5'(fr)};
      e_rword   = e_rvalid ? exp_q[0] : 9'h000;
      s_stat    = {wready, rvalid, full, empty, drop, frame_cnt};
      s_rword   = {rlast, rdata};
      h_w       = wvalid && e_wready;
      h_r       = rready && e_rvalid;
      h_wword   = {wlast, wdata};
      if (rvalid && rready) got_q.push_back(s_rword);
      @(posedge clk);
      cyc++;
      m_drop = 1'b0;
      if (!rstn) begin
         exp_q.delete();
         pend_q.delete();
         m_disc = 1'b0;
      end else begin
         if (h_r) void'(exp_q.pop_front());
`ifdef TX_FIFO_ABORT_EN
         if (wabort && !m_disc && pend_q.size() != 0) begin
            pend_q.delete();
            m_drop = 1'b1;
         end else
`endif
         if (m_disc) begin
            if (h_w && h_wword[8]) begin
               m_disc = 1'b0;
               m_drop = 1'b1;
            end
         end else if (h_w) begin
            if (h_wword[8]) begin
               foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
               exp_q.push_back(h_wword);
               pend_q.delete();
            end else if (used + 1 == DEPTH && fr == 0) begin
               pend_q.delete();
               m_disc = 1'b1;
            end else begin
               pend_q.push_back(h_wword);
            end
         end else if (pend_q.size() != 0 && e_full && fr == 0) begin
            pend_q.delete();
            m_disc = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Drive one cycle from src_q with the given write/read probabilities (percent), then advance.
   task automatic step(input int wprob, input int rprob);
      wvalid = (src_q.size() != 0) && ($urandom_range(99) < wprob);
      if (wvalid) {wlast, wdata} = src_q[0];
      else        {wlast, wdata} = {1'b0, 8'($urandom)};
      rready = ($urandom_range(99) < rprob);
      tick();
      if (h_w) void'(src_q.pop_front());
   endtask

   task automatic load_frame(input logic [7:0] base, input int len);
      for (int i = 0; i < len; i++) src_q.push_back({(i == len - 1), base + 8'(i)});
   endtask

   task automatic test_reset();
      rstn = 1'b0; wvalid = 1'b0; rready = 1'b0; wabort = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      n_chk++; if (rvalid !== 1'b0)     begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
      n_chk++; if (empty !== 1'b1)      begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
      n_chk++; if (full !== 1'b0)       begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
      n_chk++; if (frame_cnt !== 5'd0)  begin n_err++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
      n_chk++; if (wready !== 1'b1)     begin n_err++; $display("FAIL reset_wready got=%b exp=1", wready); end
      n_chk++; if (drop !== 1'b0)       begin n_err++; $display("FAIL reset_drop got=%b exp=0", drop); end
   endtask

   task automatic test_store_fwd();
      int wl_cyc = -1, rv_cyc = -1, g = 0;
      got_q.delete();
      load_frame(8'h10, 5);
      while (got_q.size() < 5 && g < 40) begin
         step(100, 100); g++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL sf_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
         if (e_rvalid) begin
            n_chk++; if (s_rword !== e_rword) begin n_err++; $display("FAIL sf_rword cyc=%0d got=%h exp=%h", cyc, s_rword, e_rword); end
         end
         if (h_w && h_wword[8]) wl_cyc = cyc;
         if (s_stat[8] && rv_cyc < 0) rv_cyc = cyc;
      end
      n_chk++; if (g >= 40) begin n_err++; $display("FAIL sf_timeout got=%0d reads exp=5", got_q.size()); end
      n_chk++; if (rv_cyc !== wl_cyc + 1) begin n_err++; $display("FAIL sf_latency got=%0d exp=%0d", rv_cyc, wl_cyc + 1); end
      for (int i = 0; i < 5; i++) begin
         logic [8:0] want;
         want = {(i == 4), 8'h10 + 8'(i)};
         n_chk++;
         if (i >= got_q.size() || got_q[i] !== want) begin
            n_err++; $display("FAIL sf_data idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, want);
         end
      end
      n_chk++; if (frame_cnt !== 5'd0) begin n_err++; $display("FAIL sf_frame_cnt got=%0d exp=0", frame_cnt); end
   endtask

   task automatic test_backpressure();
      int g = 0, acc = 0;
      got_q.delete();
      load_frame(8'hA0, 10);
      while (src_q.size() != 0 && g < 30) begin
         step(100, 0); g++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL bp_a_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
      end
      load_frame(8'hB0, 8);
      for (int i = 0; i < 12; i++) begin
         step(100, 0);
         if (h_w) acc++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL bp_b_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
      end
      n_chk++; if (acc != 6)       begin n_err++; $display("FAIL bp_accepted got=%0d exp=6", acc); end
      n_chk++; if (wready !== 1'b0) begin n_err++; $display("FAIL bp_wready got=%b exp=0", wready); end
      n_chk++; if (full !== 1'b1)   begin n_err++; $display("FAIL bp_full got=%b exp=1", full); end
      g = 0;
      while (got_q.size() < 10 && g < 30) begin
         step(100, 100); g++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL bp_c_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
         if (e_rvalid) begin
            n_chk++; if (s_rword !== e_rword) begin n_err++; $display("FAIL bp_c_rword cyc=%0d got=%h exp=%h", cyc, s_rword, e_rword); end
         end
      end
      g = 0;
      while (src_q.size() != 0 && g < 30) begin
         step(100, 0); g++;
      end
      n_chk++; if (frame_cnt !== 5'd1) begin n_err++; $display("FAIL bp_frame_cnt got=%0d exp=1", frame_cnt); end
      g = 0;
      while (got_q.size() < 18 && g < 40) begin
         step(100, 100); g++;
         if (e_rvalid) begin
            n_chk++; if (s_rword !== e_rword) begin n_err++; $display("FAIL bp_d_rword cyc=%0d got=%h exp=%h", cyc, s_rword, e_rword); end
         end
      end
      for (int i = 0; i < 18; i++) begin
         logic [8:0] want;
         want = (i < 10) ? {(i == 9), 8'hA0 + 8'(i)} : {(i == 17), 8'hB0 + 8'(i - 10)};
         n_chk++;
         if (i >= got_q.size() || got_q[i] !== want) begin
            n_err++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, want);
         end
      end
   endtask

   task automatic test_oversize();
      int g = 0, drops = 0, tail = 0;
      got_q.delete();
      load_frame(8'hC0, 20);
      while ((src_q.size() != 0 || tail < 3) && g < 60) begin
         if (src_q.size() == 0) tail++;
         step(100, 100); g++;
         if (s_stat[5]) drops++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL ov_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
      end
      n_chk++; if (drops != 1)          begin n_err++; $display("FAIL ov_drops got=%0d exp=1", drops); end
      n_chk++; if (frame_cnt !== 5'd0)  begin n_err++; $display("FAIL ov_frame_cnt got=%0d exp=0", frame_cnt); end
      n_chk++; if (empty !== 1'b1)      begin n_err++; $display("FAIL ov_empty got=%b exp=1", empty); end
      n_chk++; if (got_q.size() != 0)   begin n_err++; $display("FAIL ov_leak got=%0d bytes exp=0", got_q.size()); end
      load_frame(8'hD0, 3);
      g = 0;
      while (got_q.size() < 3 && g < 30) begin
         step(100, 100); g++;
      end
      for (int i = 0; i < 3; i++) begin
         logic [8:0] want;
         want = {(i == 2), 8'hD0 + 8'(i)};
         n_chk++;
         if (i >= got_q.size() || got_q[i] !== want) begin
            n_err++; $display("FAIL ov_next_data idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, want);
         end
      end
   endtask

   task automatic test_wrap();
      logic [8:0] ref_q[$];
      logic [AB:0] pre;
      int g = 0, coinc = 0;
      got_q.delete();
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 7; i++) begin
            src_q.push_back({(i == 6), 8'($urandom)});
            ref_q.push_back(src_q[src_q.size() - 1]);
         end
      end
      while (got_q.size() < 280 && g < 3000) begin
         step(70, 50); g++;
         n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL wr_status cyc=%0d got=%b exp=%b", cyc, s_stat, e_stat); end
         if (e_rvalid) begin
            n_chk++; if (s_rword !== e_rword) begin n_err++; $display("FAIL wr_rword cyc=%0d got=%h exp=%h", cyc, s_rword, e_rword); end
         end
         if (h_w && h_wword[8] && h_r && e_rword[8]) begin
            pre = s_stat[4:0];
            coinc++;
            n_chk++; if (frame_cnt !== pre) begin n_err++; $display("FAIL wr_coincide cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, pre); end
         end
      end
      n_chk++; if (g >= 3000) begin n_err++; $display("FAIL wr_timeout got=%0d reads exp=280", got_q.size()); end
      for (int i = 0; i < 280; i++) begin
         n_chk++;
         if (i >= got_q.size() || got_q[i] !== ref_q[i]) begin
            n_err++; $display("FAIL wr_data idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, ref_q[i]);
         end
      end
      $display("wrap: %0d cycles, %0d coincident commit/consume cycles", g, coinc);
   endtask

`ifdef TX_FIFO_ABORT_EN
   task automatic test_abort();
      int g = 0;
      got_q.delete();
      for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 8'hE0 + 8'(i)});
      while (src_q.size() != 0 && g < 20) begin
         step(100, 0); g++;
      end
      wvalid = 1'b1; wdata = 8'hEE; wlast = 1'b0; wabort = 1'b1; rready = 1'b0;
      tick();
      wabort = 1'b0; wvalid = 1'b0;
      tick();
      n_chk++; if (s_stat !== e_stat) begin n_err++; $display("FAIL ab_status got=%b exp=%b", s_stat, e_stat); end
      n_chk++; if (s_stat[5] !== 1'b1) begin n_err++; $display("FAIL ab_drop got=%b exp=1", s_stat[5]); end
      n_chk++; if (empty !== 1'b1)     begin n_err++; $display("FAIL ab_empty got=%b exp=1", empty); end
      n_chk++; if (rvalid !== 1'b0)    begin n_err++; $display("FAIL ab_rvalid got=%b exp=0", rvalid); end
      load_frame(8'hF0, 2);
      g = 0;
      while (got_q.size() < 2 && g < 20) begin
         step(100, 100); g++;
      end
      for (int i = 0; i < 2; i++) begin
         logic [8:0] want;
         want = {(i == 1), 8'hF0 + 8'(i)};
         n_chk++;
         if (i >= got_q.size() || got_q[i] !== want) begin
            n_err++; $display("FAIL ab_data idx=%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, want);
         end
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_store_fwd();
      test_backpressure();
      test_oversize();
      test_wrap();
`ifdef TX_FIFO_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d errors=%0d checks=%0d", cyc, n_err, n_chk);
      $fatal(1, "simulation time limit reached");
   end

endmodule
